// File: rtl/uart_cmd_parser_if.sv
// Port bundle for uart_cmd_parser: the RX FIFO pop side
// (rx_empty / read_data / read_uart) and the command valid/ready side
// (cmd_valid / cmd_ready / cmd_len / cmd_payload).
// The parser connects through the master modport; whatever feeds the FIFO
// and consumes the commands connects through the slave modport.
interface uart_cmd_parser_if #(
  parameter int WIDTH       = 8,
  parameter int MAX_PAYLOAD = 16
);
  logic                         rx_empty;
  logic [WIDTH-1:0]             read_data;
  logic                         read_uart;
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [7:0]                   cmd_len;
  logic [MAX_PAYLOAD*WIDTH-1:0] cmd_payload;

  modport master (
    input  rx_empty, read_data, cmd_ready,
    output read_uart, cmd_valid, cmd_len, cmd_payload
  );

  modport slave (
    output rx_empty, read_data, cmd_ready,
    input  read_uart, cmd_valid, cmd_len, cmd_payload
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: pops bytes from a first-word-fall-through RX FIFO, hunts
// for SOF, assembles SOF/LEN/payload/CHK frames and presents each good frame
// as one parallel command on a valid/ready handshake. Malformed frames raise
// one-cycle error pulses and bump a saturating error counter.
// Optional build macro UART_CMD_PARSER_TIMEOUT_EN adds an inter-byte timeout
// that drops a stalled partial frame after TIMEOUT_CYCLES idle cycles.
module uart_cmd_parser #(
  parameter int               WIDTH          = 8,
  parameter int               MAX_PAYLOAD    = 16,
  parameter logic [WIDTH-1:0] SOF            = 8'hA5,
  parameter int               TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_cmd_parser_if.master        bus,
  output logic                     chk_error,
  output logic                     len_error,
  output logic                     timeout_error,
  output logic [15:0]              err_count
);

  if (MAX_PAYLOAD < 1 || MAX_PAYLOAD > 255 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_cmd_parser: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAY,
    S_CHK,
    S_HOLD
  } state_t;

  localparam logic [WIDTH-1:0] MAX_LEN = WIDTH'(MAX_PAYLOAD);

  state_t                       state;
  logic [7:0]                   len_q;
  logic [7:0]                   idx_q;
  logic [WIDTH-1:0]             sum_q;
  logic [WIDTH-1:0]             chk_sum;
  logic                         cmd_valid_q;
  logic [7:0]                   cmd_len_q;
  logic [MAX_PAYLOAD*WIDTH-1:0] payload_q;
  logic                         pop;
  logic                         tmo_hit;

  // Pop whenever a byte is waiting and we are not holding a command.
  // NOTE: continuous assign for combinational outputs; no process, so no latch can be inferred.
  assign pop           = reset && !bus.rx_empty && (state != S_HOLD);
  assign bus.read_uart = pop;

  // Running checksum including the byte currently at the FIFO head (mod 2^WIDTH).
  assign chk_sum = sum_q + bus.read_data;

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_len     = cmd_len_q;
  assign bus.cmd_payload = payload_q;

`ifdef UART_CMD_PARSER_TIMEOUT_EN
  logic        in_frame;
  logic [31:0] tmo_cnt;
  logic        tmo_q;

  assign in_frame = (state == S_LEN) || (state == S_PAY) || (state == S_CHK);
  assign tmo_hit  = in_frame && !pop && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter: runs only mid-frame, restarts on every pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (!in_frame || pop || tmo_hit) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign timeout_error = tmo_q;
`else
  assign tmo_hit       = 1'b0;
  assign timeout_error = 1'b0;
`endif

  // Frame FSM with registered command outputs and error pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_HUNT;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_len_q   <= '0;
      // NOTE: the payload register is reset because it is an output that must read 0 after reset.
      payload_q   <= '0;
      chk_error   <= 1'b0;
      len_error   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      chk_error <= 1'b0;
      len_error <= 1'b0;
      if (tmo_hit) begin
        state <= S_HUNT;
      end else begin
        case (state)
          S_HUNT: begin
            if (pop && bus.read_data == SOF) begin
              payload_q <= '0;
              state     <= S_LEN;
            end
          end
          S_LEN: begin
            if (pop) begin
              len_q <= 8'(bus.read_data);
              sum_q <= bus.read_data;
              idx_q <= '0;
              if (bus.read_data > MAX_LEN) begin
                len_error <= 1'b1;
                state     <= S_HUNT;
              end else if (bus.read_data == '0) begin
                state <= S_CHK;
              end else begin
                state <= S_PAY;
              end
            end
          end
          S_PAY: begin
            if (pop) begin
              for (int i = 0; i < MAX_PAYLOAD; i++) begin
                if (idx_q == 8'(i)) payload_q[WIDTH*i +: WIDTH] <= bus.read_data;
              end
              sum_q <= chk_sum;
              idx_q <= idx_q + 8'd1;
              if (idx_q == len_q - 8'd1) state <= S_CHK;
            end
          end
          S_CHK: begin
            if (pop) begin
              if (chk_sum == '0) begin
                cmd_len_q   <= len_q;
                cmd_valid_q <= 1'b1;
                state       <= S_HOLD;
              end else begin
                chk_error <= 1'b1;
                state     <= S_HUNT;
              end
            end
          end
          S_HOLD: begin
            if (bus.cmd_ready) begin
              cmd_valid_q <= 1'b0;
              state       <= S_HUNT;
            end
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

  // Saturating count of error pulses, one increment per pulse cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if ((chk_error || len_error || timeout_error) && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: a queue-modelled FWFT RX FIFO feeds byte
// streams from a vector table; expected commands go on a scoreboard when a
// frame is queued and are compared whenever cmd_valid is seen. Hand-written
// sequences cover latency, back-pressure, reset mid-frame and timeout.
module tb_uart_cmd_parser;
  localparam int WIDTH          = 8;
  localparam int MAX_PAYLOAD    = 16;
  localparam int TIMEOUT_CYCLES = 50;
  localparam int PW             = WIDTH * MAX_PAYLOAD;

  typedef struct {
    int          n;        // bytes in stream, first byte most significant
    logic [159:0] stream;
    bit          good;     // stream ends in exactly one deliverable command
    logic [7:0]  len;
    logic [PW-1:0] pay;
    int          n_chk;
    int          n_lenerr;
  } vec_t;

  typedef struct {
    logic [7:0]    len;
    logic [PW-1:0] pay;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chk_error;
  logic        len_error;
  logic        timeout_error;
  logic [15:0] err_count;

  uart_cmd_parser_if #(.WIDTH(WIDTH), .MAX_PAYLOAD(MAX_PAYLOAD)) bus ();

  uart_cmd_parser #(
    .WIDTH(WIDTH), .MAX_PAYLOAD(MAX_PAYLOAD), .SOF(8'hA5), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bus),
    .chk_error(chk_error), .len_error(len_error),
    .timeout_error(timeout_error), .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo [$];
  exp_t       sb [$];
  vec_t       vecs [7];

  int n_vec = 0, n_bad = 0;
  int cyc = 0, last_pop_cyc = 0, tmo_cyc = 0;
  int obs_chk = 0, obs_len = 0, obs_tmo = 0, delivered = 0, exp_err = 0;
  bit pop_pending = 1'b0, ready_want = 1'b1;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh_fifo();
    bus.rx_empty  = (fifo.size() == 0);
    bus.read_data = (fifo.size() != 0) ? fifo[0] : 8'h00;
    #1;
    pop_pending = bus.read_uart;
  endtask

  task automatic monitor();
    if (bus.cmd_valid) begin
      check("hold_no_pop", bus.read_uart, 1'b0);
      check("cmd_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        check("cmd_len", bus.cmd_len, sb[0].len);
        check("cmd_payload", bus.cmd_payload, sb[0].pay);
        if (bus.cmd_ready) begin
          void'(sb.pop_front());
          delivered++;
        end
      end
    end
    if (chk_error) obs_chk++;
    if (len_error) obs_len++;
    if (timeout_error) begin
      obs_tmo++;
      tmo_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (pop_pending) last_pop_cyc = cyc;
    @(negedge clk);
    if (pop_pending) void'(fifo.pop_front());
    bus.cmd_ready = ready_want;
    refresh_fifo();
    monitor();
  endtask

  task automatic push_stream(input int n, input logic [159:0] stream);
    for (int k = 0; k < n; k++) fifo.push_back(stream[8*(n-1-k) +: 8]);
    refresh_fifo();
  endtask

  function automatic bit drained();
    return fifo.size() == 0 && sb.size() == 0 && !bus.cmd_valid && !pop_pending;
  endfunction

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 300; k++) begin
      if (drained()) break;
      tick();
    end
    check({tag, "_drain"}, drained(), 1'b1);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    refresh_fifo();
    repeat (3) tick();
    rst_n = 1'b1;
    fifo.delete();
    sb.delete();
    exp_err = 0;
    refresh_fifo();
    tick();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int c0, l0, d0;
    c0 = obs_chk;
    l0 = obs_len;
    d0 = delivered;
    ready_want = 1'b1;
    if (v.good) sb.push_back('{len: v.len, pay: v.pay});
    exp_err += v.n_chk + v.n_lenerr;
    push_stream(v.n, v.stream);
    wait_drain(tag);
    check({tag, "_chk_pulses"}, obs_chk - c0, v.n_chk);
    check({tag, "_len_pulses"}, obs_len - l0, v.n_lenerr);
    check({tag, "_delivered"}, delivered - d0, v.good ? 1 : 0);
    check({tag, "_err_count"}, err_count, exp_err);
  endtask

  initial begin
    int lat, t0, d0, c0, l0;

    vecs[0] = '{n: 6,  stream: 160'hA50311223397, good: 1'b1, len: 8'd3,
                pay: 128'h332211, n_chk: 0, n_lenerr: 0};
    vecs[1] = '{n: 6,  stream: 160'hA50311223300, good: 1'b0, len: 8'd0,
                pay: 128'h0, n_chk: 1, n_lenerr: 0};
    vecs[2] = '{n: 3,  stream: 160'hA50000, good: 1'b1, len: 8'd0,
                pay: 128'h0, n_chk: 0, n_lenerr: 0};
    vecs[3] = '{n: 19, stream: 160'hA510_0102030405060708_090A0B0C0D0E0F10_68, good: 1'b1,
                len: 8'd16, pay: 128'h100F0E0D0C0B0A090807060504030201, n_chk: 0, n_lenerr: 0};
    vecs[4] = '{n: 8,  stream: 160'h00FFA511A5015AA5, good: 1'b1, len: 8'd1,
                pay: 128'h5A, n_chk: 0, n_lenerr: 1};
    vecs[5] = '{n: 5,  stream: 160'hA502A5A5B4, good: 1'b1, len: 8'd2,
                pay: 128'hA5A5, n_chk: 0, n_lenerr: 0};
    vecs[6] = '{n: 4,  stream: 160'hA501FF00, good: 1'b1, len: 8'd1,
                pay: 128'hFF, n_chk: 0, n_lenerr: 0};

    rst_n         = 1'b0;
    bus.rx_empty  = 1'b1;
    bus.read_data = 8'h00;
    bus.cmd_ready = 1'b0;
    repeat (3) tick();
    check("rst_cmd_valid", bus.cmd_valid, 1'b0);
    check("rst_cmd_len", bus.cmd_len, 8'd0);
    check("rst_cmd_payload", bus.cmd_payload, 128'h0);
    check("rst_read_uart", bus.read_uart, 1'b0);
    check("rst_chk_error", chk_error, 1'b0);
    check("rst_len_error", len_error, 1'b0);
    check("rst_timeout_error", timeout_error, 1'b0);
    check("rst_err_count", err_count, 16'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Latency and back-pressure: two frames queued, consumer stalls 10 cycles.
    ready_want = 1'b0;
    d0 = delivered;
    sb.push_back('{len: 8'd2, pay: 128'h0201});
    sb.push_back('{len: 8'd3, pay: 128'h332211});
    push_stream(11, 160'hA5020102FB_A50311223397);
    lat = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (bus.cmd_valid) begin
        lat = t;
        break;
      end
    end
    check("latency", lat, 5);
    repeat (10) tick();
    check("bp_fifo_level", fifo.size(), 6);
    check("bp_still_valid", bus.cmd_valid, 1'b1);
    ready_want = 1'b1;
    wait_drain("bp");
    check("bp_delivered", delivered - d0, 2);
    check("bp_err_count", err_count, exp_err);

    // Inter-byte timeout: stall after A5 02 11.
    t0 = obs_tmo;
    push_stream(3, 160'hA50211);
    for (int k = 0; k < 20 && fifo.size() != 0; k++) tick();
    repeat (60) tick();
`ifdef UART_CMD_PARSER_TIMEOUT_EN
    exp_err++;
    check("tmo_pulses", obs_tmo - t0, 1);
    check("tmo_delay", tmo_cyc - last_pop_cyc, TIMEOUT_CYCLES);
    check("tmo_err_count", err_count, exp_err);
    d0 = delivered;
    sb.push_back('{len: 8'd0, pay: 128'h0});
    push_stream(3, 160'hA50000);
    wait_drain("tmo_recover");
    check("tmo_recover_delivered", delivered - d0, 1);
`else
    check("tmo_pulses", obs_tmo - t0, 0);
    check("tmo_err_count", err_count, exp_err);
`endif
    do_reset();

    // Reset mid-frame: partial frame dropped, no error after release.
    push_stream(3, 160'hA50211);
    for (int k = 0; k < 20 && fifo.size() != 0; k++) tick();
    do_reset();
    c0 = obs_chk + obs_len + obs_tmo;
    d0 = delivered;
    sb.push_back('{len: 8'd1, pay: 128'h07});
    push_stream(4, 160'hA50107F8);
    wait_drain("rstmid");
    check("rstmid_delivered", delivered - d0, 1);
    l0 = obs_chk + obs_len + obs_tmo;
    check("rstmid_no_pulses", l0 - c0, 0);
    check("rstmid_err_count", err_count, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART core's RX FIFO.
- Pops received bytes, hunts for a start-of-frame byte, and assembles length-prefixed, checksummed command frames.
- Presents each good frame as one parallel command word on a valid/ready interface to the application logic.
- Counts and flags malformed frames; the FIFO is back-pressured while a command is waiting to be taken.

Parameters:
- WIDTH, 8, byte width; must match the UART core data width.
- MAX_PAYLOAD, 16, maximum payload bytes per frame (1..255).
- SOF, 8'hA5, start-of-frame byte value.
- TIMEOUT_CYCLES, 1_000_000, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_empty  input  1  RX FIFO empty flag.
- read_data  input  WIDTH  RX FIFO head byte; first-word-fall-through, valid whenever rx_empty=0.
- read_uart  output  1  RX FIFO pop; head byte is consumed in the same cycle.
- cmd_valid  output  1  command available.
- cmd_ready  input  1  consumer accepts the command.
- cmd_len  output  8  payload length of the current command (0..MAX_PAYLOAD).
- cmd_payload  output  MAX_PAYLOAD*WIDTH  payload; byte i sits at [WIDTH*i +: WIDTH]; bytes >= cmd_len read as 0.
- chk_error  output  1  one-cycle pulse: checksum mismatch.
- len_error  output  1  one-cycle pulse: LEN > MAX_PAYLOAD.
- timeout_error  output  1  one-cycle pulse: inter-byte timeout (tied 0 without the optional feature).
- err_count  output  16  saturating count of all error pulses.

Behaviour:
- Reset (reset=0, async): state=HUNT; counters 0; cmd_payload 0; cmd_len 0; all outputs 0.
- Frame format: SOF, LEN, LEN payload bytes, CHK.
  - Good frame: (LEN + sum(payload) + CHK) mod 256 == 0.
- read_uart = !rx_empty && state in {HUNT, LEN, PAY, CHK}.
  - Combinational, at most one pop per cycle.
  - Never asserted in HOLD.
- HUNT: popped byte == SOF -> LEN, and cmd_payload is cleared to 0. Any other byte is discarded; stay in HUNT.
- LEN: pop byte L.
  - L > MAX_PAYLOAD: len_error pulse next cycle, go to HUNT.
  - L == 0: go to CHK.
  - Otherwise go to PAY, byte index=0.
  - In all cases sum=L.
- PAY: each pop stores the byte at the current index, sum += byte (8-bit wrap), index++. After byte L-1 go to CHK.
- CHK: pop byte C.
  - (sum + C) mod 256 == 0: cmd_len=L, go to HOLD; cmd_valid=1 the cycle after the CHK pop.
  - Else: chk_error pulse next cycle, go to HUNT; cmd_valid stays 0.
- HOLD: cmd_valid=1; cmd_len/cmd_payload held stable.
  - On cmd_valid && cmd_ready: cmd_valid=0 next cycle, go to HUNT.
  - The earliest next pop is the cycle after the handshake.
- Latency: a frame of L bytes needs L+3 pops. With a continuously non-empty FIFO, cmd_valid rises L+3 cycles after the first SOF pop cycle.
- Outputs are registered; cmd_ready has no combinational path to cmd_valid.
- A byte equal to SOF inside LEN/PAY/CHK is data, not a resync.
- err_count increments by 1 on each error pulse and saturates at 16'hFFFF.
- Reset asserted mid-frame: the partial frame is dropped, and no error pulse is produced after release.

Optional Feature:
- Macro: UART_CMD_PARSER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in LEN/PAY/CHK; it clears on every pop and on entry to those states.
  - When it reaches TIMEOUT_CYCLES-1 without a pop: timeout_error pulse, err_count++, partial frame dropped, go to HUNT.
  - The counter is inactive in HUNT and HOLD.
- Undefined: no counter is built, timeout_error is tied 0, and the parser waits indefinitely mid-frame.

Test Plan:
- Good frame: FIFO A5 03 11 22 33 97, cmd_ready=1 -> one cmd_valid cycle; cmd_len=3; payload bytes 0..2 = 11,22,33, rest 0; no error pulses.
- Bad checksum: A5 03 11 22 33 00 -> chk_error single pulse; err_count=1; cmd_valid never asserted; then A5 00 00 -> cmd_valid with cmd_len=0.
- Hunt and length error: 00 FF A5 11 A5 01 5A A5 -> first A5 gives len_error (0x11 > 16); the next A5 frame yields cmd_len=1, payload byte0=5A.
- Back-pressure: two queued good frames, cmd_ready=0 for 10 cycles after cmd_valid -> read_uart=0 throughout, payload stable; after ready, the second frame is delivered intact.
- Reset mid-frame: reset low after A5 02 11, then release and feed A5 01 07 F8 -> only the second frame is delivered; err_count=0.
- Timeout (macro defined, TIMEOUT_CYCLES=50): A5 02 11 then no bytes for 60 cycles -> timeout_error pulse 50 cycles after the last pop, state back to HUNT. Without the macro: no pulse.
